// File: rtl/effect_pkg.sv
// Shared definitions for the effect data path.
//   sched_state_e   : scheduler state encoding
//   ch_id_width()   : channel-tag width, never narrower than one bit
//   narrow_sample() : audio width -> effect width (keep upper bits, truncate)
//   widen_sample()  : effect width -> audio width (zero-fill low bits)
// The sample helpers work on a fixed 64-bit container so that the
// scheduler and the two-channel controller can share them for any widths
// up to 64 bits; callers size-cast the result to their own width.
package effect_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } sched_state_e;

  localparam int SAMPLE_MAX_W = 64;

  function automatic int ch_id_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic logic [SAMPLE_MAX_W-1:0] narrow_sample(
    input logic [SAMPLE_MAX_W-1:0] s,
    input int                      d_w,
    input int                      e_w
  );
    return s >> (d_w - e_w);
  endfunction

  function automatic logic [SAMPLE_MAX_W-1:0] widen_sample(
    input logic [SAMPLE_MAX_W-1:0] s,
    input int                      d_w,
    input int                      e_w
  );
    return s << (d_w - e_w);
  endfunction

endpackage

// File: rtl/effect_stream_scheduler_watchdog.sv
// effect_watchdog_timer: response watchdog for the stream scheduler.
//   clk, reset_n : system clock / async active-low reset
//   clear        : arm the timer for a fresh wait (a transfer just happened)
//   enable       : the scheduler is waiting for an effect result
//   expire       : high in the TIMEOUT-th enabled cycle after clear
// Implemented as a down-counter: clear loads TIMEOUT-1, every enabled cycle
// decrements, and terminal count zero while enabled is the expiry.
module effect_watchdog_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = TW'(TIMEOUT - 1);
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/effect_stream_scheduler.sv
// effect_stream_scheduler: takes one I2S frame of N_CH samples, streams the
// non-bypassed channels one by one to the shared effect module and gathers
// the results back into an output frame.
//   i_frame_data/valid/i_bypass : received frame, strobe, per-channel bypass
//   o_data_to_eff/o_ch_id/o_data_valid, i_read_enable : stream to effect
//   i_data_from_eff/i_dv_from_eff : processed sample back from effect
//   o_frame_data/o_frame_valid  : frame to transmit (data held until next)
//   o_busy, o_timeout, o_overrun : status (timeout/overrun are 1-cycle pulses)
//
// state | meaning
// IDLE  | waiting for a frame strobe
// SCAN  | pick the next channel: copy bypassed ones, finish after the last
// SEND  | offer in_buf[ch] to the effect module until it is accepted
// WAIT  | wait for the effect result or watchdog expiry
// DONE  | publish out_buf as the output frame
module effect_stream_scheduler
  import effect_pkg::*;
#(
  parameter  int N_CH    = 2,
  parameter  int D_WIDTH = 24,
  parameter  int E_WIDTH = 16,
  parameter  int TIMEOUT = 1024,
  localparam int CH_W    = ch_id_width(N_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH*D_WIDTH-1:0] i_frame_data,
  input  logic                    i_frame_valid,
  input  logic [N_CH-1:0]         i_bypass,
  output logic [E_WIDTH-1:0]      o_data_to_eff,
  output logic [CH_W-1:0]         o_ch_id,
  output logic                    o_data_valid,
  input  logic                    i_read_enable,
  input  logic [E_WIDTH-1:0]      i_data_from_eff,
  input  logic                    i_dv_from_eff,
  output logic [N_CH*D_WIDTH-1:0] o_frame_data,
  output logic                    o_frame_valid,
  output logic                    o_busy,
  output logic                    o_timeout,
  output logic                    o_overrun
);

  // ch has to be able to hold N_CH itself, the "all channels done" marker.
  localparam int CNT_W = $clog2(N_CH + 1);

  sched_state_e                     state_q, state_d;
  logic [CNT_W-1:0]                 ch_q, ch_d;
  logic [N_CH-1:0]                  byp_q, byp_d;
  logic [N_CH-1:0][D_WIDTH-1:0]     in_buf_q, in_buf_d;
  logic [N_CH-1:0][D_WIDTH-1:0]     out_buf_q, out_buf_d;
  logic [N_CH-1:0][D_WIDTH-1:0]     frame_data_q, frame_data_d;
  logic                             frame_valid_q, frame_valid_d;

  logic [CH_W-1:0]    ch_idx;
  logic               tmr_clear;
  logic               tmr_enable;
  logic               tmr_expire;
  logic               timeout_pulse;
  logic [D_WIDTH-1:0] eff_widened;

  assign ch_idx      = ch_q[CH_W-1:0];
  assign tmr_enable  = (state_q == WAIT);
  assign eff_widened = D_WIDTH'(widen_sample(SAMPLE_MAX_W'(i_data_from_eff),
                                             D_WIDTH, E_WIDTH));

  effect_watchdog_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    byp_d         = byp_q;
    in_buf_d      = in_buf_q;
    out_buf_d     = out_buf_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    tmr_clear     = 1'b0;
    timeout_pulse = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_frame_valid) begin
          in_buf_d = i_frame_data;
          byp_d    = i_bypass;
          ch_d     = '0;
          state_d  = SCAN;
        end
      end

      SCAN: begin
        if (ch_q == CNT_W'(N_CH)) begin
          state_d = DONE;
        end else if (byp_q[ch_idx]) begin
          out_buf_d[ch_idx] = in_buf_q[ch_idx];
          ch_d              = ch_q + CNT_W'(1);
        end else begin
          state_d = SEND;
        end
      end

      SEND: begin
        if (i_read_enable) begin
          tmr_clear = 1'b1;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        // A result arriving in the expiry cycle still wins over the watchdog.
        if (i_dv_from_eff) begin
          out_buf_d[ch_idx] = eff_widened;
          ch_d              = ch_q + CNT_W'(1);
          state_d           = SCAN;
        end else if (tmr_expire) begin
          out_buf_d[ch_idx] = in_buf_q[ch_idx];
          timeout_pulse     = 1'b1;
          ch_d              = ch_q + CNT_W'(1);
          state_d           = SCAN;
        end
      end

      DONE: begin
        frame_data_d  = out_buf_q;
        frame_valid_d = 1'b1;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      byp_q         <= '0;
      in_buf_q      <= '0;
      out_buf_q     <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      byp_q         <= byp_d;
      in_buf_q      <= in_buf_d;
      out_buf_q     <= out_buf_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Stream outputs are forced to zero outside SEND so the bus is quiet
  // (and zero during reset) whenever no sample is being offered.
  assign o_data_valid  = (state_q == SEND);
  assign o_data_to_eff = o_data_valid
                         ? E_WIDTH'(narrow_sample(SAMPLE_MAX_W'(in_buf_q[ch_idx]),
                                                  D_WIDTH, E_WIDTH))
                         : '0;
  assign o_ch_id       = o_data_valid ? ch_idx : '0;

  assign o_frame_data  = frame_data_q;
  assign o_frame_valid = frame_valid_q;
  assign o_busy        = (state_q != IDLE);
  assign o_timeout     = timeout_pulse;
  assign o_overrun     = i_frame_valid && (state_q != IDLE);

endmodule

// File: tb/tb_effect_stream_scheduler.sv
module tb_effect_stream_scheduler;

  localparam int N_CH    = 2;
  localparam int D_WIDTH = 24;
  localparam int E_WIDTH = 16;
  localparam int TIMEOUT = 8;
  localparam int CH_W    = 1;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [N_CH*D_WIDTH-1:0] i_frame_data;
  logic                    i_frame_valid;
  logic [N_CH-1:0]         i_bypass;
  logic [E_WIDTH-1:0]      o_data_to_eff;
  logic [CH_W-1:0]         o_ch_id;
  logic                    o_data_valid;
  logic                    i_read_enable;
  logic [E_WIDTH-1:0]      i_data_from_eff;
  logic                    i_dv_from_eff;
  logic [N_CH*D_WIDTH-1:0] o_frame_data;
  logic                    o_frame_valid;
  logic                    o_busy;
  logic                    o_timeout;
  logic                    o_overrun;

  always #5 clk = ~clk;

  effect_stream_scheduler #(
    .N_CH    (N_CH),
    .D_WIDTH (D_WIDTH),
    .E_WIDTH (E_WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_frame_data    (i_frame_data),
    .i_frame_valid   (i_frame_valid),
    .i_bypass        (i_bypass),
    .o_data_to_eff   (o_data_to_eff),
    .o_ch_id         (o_ch_id),
    .o_data_valid    (o_data_valid),
    .i_read_enable   (i_read_enable),
    .i_data_from_eff (i_data_from_eff),
    .i_dv_from_eff   (i_dv_from_eff),
    .o_frame_data    (o_frame_data),
    .o_frame_valid   (o_frame_valid),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout),
    .o_overrun       (o_overrun)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Effect module stand-in: answers each accepted sample after eff_lat[tag]
  // cycles (0 = never answers) with sample^eff_key, or 0x7FFF in const mode.
  int          eff_lat [N_CH];
  logic        eff_const;
  logic [15:0] eff_key;
  int          re_hold;
  bit          re_rand;
  int          pend_cnt;
  logic [15:0] pend_data;

  initial begin : effect_responder
    i_read_enable   = 1'b0;
    i_dv_from_eff   = 1'b0;
    i_data_from_eff = '0;
    pend_cnt        = 0;
    pend_data       = '0;
    forever begin
      @(negedge clk);
      i_dv_from_eff = 1'b0;
      if (!reset_n) begin
        pend_cnt = 0;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          i_dv_from_eff   = 1'b1;
          i_data_from_eff = pend_data;
        end
      end
      if (re_hold > 0) begin
        i_read_enable = 1'b0;
        re_hold--;
      end else if (re_rand) begin
        i_read_enable = ($urandom_range(0, 3) != 0);
      end else begin
        i_read_enable = 1'b1;
      end
      if (o_data_valid && i_read_enable && eff_lat[o_ch_id] > 0) begin
        pend_data = eff_const ? 16'h7FFF : (o_data_to_eff ^ eff_key);
        pend_cnt  = eff_lat[o_ch_id];
      end
    end
  end

  // Output observer, sampling well after the falling edge.
  int          s_tag [$];
  logic [15:0] s_data [$];
  int          to_dly [$];
  int          x_cyc = 0;
  int          fv_cnt = 0;
  int          fv_cyc = 0;
  logic [47:0] fv_data = '0;
  int          ov_cnt = 0;
  int          dv_cyc_cnt = 0;

  initial begin : observer
    forever begin
      @(negedge clk);
      #1;
      if (o_data_valid && i_read_enable) begin
        s_tag.push_back(int'(o_ch_id));
        s_data.push_back(o_data_to_eff);
        x_cyc = cyc;
      end
      if (o_timeout)     to_dly.push_back(cyc - x_cyc);
      if (o_frame_valid) begin
        fv_cnt++;
        fv_cyc  = cyc;
        fv_data = o_frame_data;
      end
      if (o_overrun)     ov_cnt++;
      if (o_data_valid)  dv_cyc_cnt++;
    end
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_time_limit observed=expired required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bypass -> original; answered within TIMEOUT -> response in
  // the upper bits with zero low bits; otherwise the original is kept.
  function automatic logic [47:0] model_frame(input logic [47:0] d, input logic [1:0] b);
    logic [47:0] r;
    logic [23:0] s;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      s = d[k*24 +: 24];
      if (b[k] || eff_lat[k] == 0 || eff_lat[k] > TIMEOUT)
        r[k*24 +: 24] = s;
      else
        r[k*24 +: 24] = {(eff_const ? 16'h7FFF : (s[23:8] ^ eff_key)), 8'h00};
    end
    return r;
  endfunction

  int cap_cyc = 0;

  task automatic send_frame(input logic [47:0] d, input logic [1:0] b);
    s_tag.delete();
    s_data.delete();
    to_dly.delete();
    dv_cyc_cnt = 0;
    @(negedge clk);
    i_frame_data  = d;
    i_bypass      = b;
    i_frame_valid = 1'b1;
    @(negedge clk);
    i_frame_valid = 1'b0;
    cap_cyc       = cyc;
  endtask

  task automatic wait_frame(input string tag, input int fv0);
    int n;
    n = 0;
    while (fv_cnt == fv0 && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk({tag, "_frame_arrived"}, 64'(fv_cnt != fv0), 64'd1);
  endtask

  task automatic check_frame(input string tag, input logic [47:0] d, input logic [1:0] b);
    logic [47:0] exp;
    int          fv0;
    int          n_to;
    int          exp_tag [$];
    exp = model_frame(d, b);
    fv0 = fv_cnt;
    send_frame(d, b);
    wait_frame(tag, fv0);
    repeat (3) @(negedge clk);
    #2;
    chk({tag, "_data"}, 64'(fv_data), 64'(exp));
    chk({tag, "_nframes"}, 64'(fv_cnt - fv0), 64'd1);
    n_to = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (!b[k]) begin
        exp_tag.push_back(k);
        if (eff_lat[k] == 0 || eff_lat[k] > TIMEOUT) n_to++;
      end
    end
    chk({tag, "_nxfer"}, 64'(s_tag.size()), 64'(exp_tag.size()));
    foreach (exp_tag[i]) begin
      if (i < s_tag.size()) begin
        chk({tag, "_xfer_tag"}, 64'(s_tag[i]), 64'(exp_tag[i]));
        chk({tag, "_xfer_data"}, 64'(s_data[i]), 64'(d[exp_tag[i]*24 + 8 +: 16]));
      end
    end
    chk({tag, "_ntimeout"}, 64'(to_dly.size()), 64'(n_to));
    foreach (to_dly[i]) chk({tag, "_timeout_delay"}, 64'(to_dly[i]), 64'(TIMEOUT));
  endtask

  initial begin : main
    logic [47:0] d;
    logic [1:0]  b;
    logic [15:0] hold_data;
    int          fv0;
    int          ov0;
    int          n;

    reset_n       = 1'b0;
    i_frame_valid = 1'b0;
    i_frame_data  = '0;
    i_bypass      = '0;
    eff_lat       = '{2, 2};
    eff_const     = 1'b0;
    eff_key       = '0;
    re_hold       = 0;
    re_rand       = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_frame_data", 64'(o_frame_data), 64'd0);
    chk("rst_ctrl", 64'({o_frame_valid, o_data_valid, o_busy, o_timeout, o_overrun,
                         o_data_to_eff, o_ch_id}), 64'd0);
    reset_n = 1'b1;

    // Plain echo, both channels through the effect.
    check_frame("echo", {24'hFEDCBA, 24'h123456}, 2'b00);
    chk("echo_frame_const", 64'(fv_data), 64'({24'hFEDC00, 24'h123400}));
    chk("echo_first_sample", 64'({s_tag[0], s_data[0]}), 64'({32'd0, 16'h1234}));
    chk("echo_second_sample", 64'({s_tag[1], s_data[1]}), 64'({32'd1, 16'hFEDC}));

    // Everything bypassed: no stream traffic, fixed latency, bit-exact output.
    check_frame("byp_all", {24'h000001, 24'hABCDEF}, 2'b11);
    chk("byp_all_latency", 64'(fv_cyc - cap_cyc), 64'(N_CH + 2));
    chk("byp_all_no_dv", 64'(dv_cyc_cnt), 64'd0);
    chk("byp_all_exact", 64'(fv_data), 64'({24'h000001, 24'hABCDEF}));

    // Left bypassed, effect returns a constant.
    eff_const = 1'b1;
    check_frame("byp_left", {24'h654321, 24'h13579B}, 2'b01);
    chk("byp_left_const", 64'(fv_data), 64'({24'h7FFF00, 24'h13579B}));
    eff_const = 1'b0;

    // Effect never answers: one timeout per channel, originals pass.
    eff_lat = '{0, 0};
    d = 48'({$urandom(), $urandom()});
    check_frame("silent", d, 2'b00);
    chk("silent_exact", 64'(fv_data), 64'(d));

    // Answer in the expiry cycle wins; one cycle later is a timeout.
    eff_lat = '{8, 9};
    eff_key = 16'h5A5A;
    d = 48'({$urandom(), $urandom()});
    check_frame("edge", d, 2'b00);
    eff_key = '0;

    // Read enable held low: stream must stay stable; a frame while busy
    // is dropped with an overrun pulse.
    eff_lat = '{2, 2};
    d   = 48'({$urandom(), $urandom()});
    fv0 = fv_cnt;
    ov0 = ov_cnt;
    re_hold = 40;
    send_frame(d, 2'b00);
    n = 0;
    while (!o_data_valid && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("hold_dv_seen", 64'(o_data_valid), 64'd1);
    hold_data = d[23:8];
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_frame_valid = (i == 5);
      i_frame_data  = ~d;
      #2;
      chk("hold_valid", 64'(o_data_valid), 64'd1);
      chk("hold_data", 64'(o_data_to_eff), 64'(hold_data));
      chk("hold_tag", 64'(o_ch_id), 64'd0);
    end
    i_frame_valid = 1'b0;
    wait_frame("hold", fv0);
    repeat (3) @(negedge clk);
    #2;
    chk("hold_overrun", 64'(ov_cnt - ov0), 64'd1);
    chk("hold_frame", 64'(fv_data), 64'(model_frame(d, 2'b00)));
    chk("hold_nframes", 64'(fv_cnt - fv0), 64'd1);

    // Reset while waiting for the effect: outputs drop immediately.
    eff_lat = '{0, 0};
    d   = 48'({$urandom(), $urandom()});
    fv0 = fv_cnt;
    send_frame(d, 2'b00);
    n = 0;
    while (s_tag.size() == 0 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("rst_mid_xfer_seen", 64'(s_tag.size()), 64'd1);
    repeat (2) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_frame_data", 64'(o_frame_data), 64'd0);
    chk("rst_mid_ctrl", 64'({o_frame_valid, o_data_valid, o_busy, o_timeout, o_overrun,
                             o_data_to_eff, o_ch_id}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    chk("rst_mid_no_frame", 64'(fv_cnt - fv0), 64'd0);
    chk("rst_mid_idle", 64'(o_busy), 64'd0);
    eff_lat = '{3, 5};
    check_frame("post_rst", 48'({$urandom(), $urandom()}), 2'b00);

    // Randomised frames, bypass masks, latencies and read-enable gaps.
    re_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      b          = 2'($urandom_range(0, 3));
      eff_lat[0] = $urandom_range(1, 10);
      eff_lat[1] = $urandom_range(1, 10);
      eff_key    = 16'($urandom());
      d          = 48'({$urandom(), $urandom()});
      check_frame("rand", d, b);
    end
    re_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
